rx_lane_fifo: RTL and testbench
===============================

RX_LANE_FIFO -- requirements
Module: rx_lane_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits.
REQ-002 Parameter DEPTH, default 8, number of entries; power of two, minimum 4.
REQ-003 Parameter AF_THRESH, default 6, almost_full asserts when count >= AF_THRESH.
REQ-004 Parameter AE_THRESH, default 2, almost_empty asserts when count <= AE_THRESH.
REQ-005 clk_f  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 data_in  input  WIDTH  lane byte from the upstream 2x4 demux output (data_rxN).
REQ-008 push  input  1  write strobe; connects to the demux valid_rxN.
REQ-009 pop  input  1  read request from the downstream consumer.
REQ-010 data_out  output  WIDTH  registered read data.
REQ-011 valid_out  output  1  data_out holds a popped entry this cycle.
REQ-012 full, empty  output  1 each  occupancy flags.
REQ-013 almost_full, almost_empty  output  1 each  threshold flags.
REQ-014 count  output  log2(DEPTH)+1  current occupancy.
REQ-015 overflow_err, underflow_err  output  1 each  sticky error flags.

Function
REQ-016 Storage SHALL be a DEPTH x WIDTH register array addressed by write and read pointers of log2(DEPTH) bits that wrap modulo DEPTH.
REQ-017 Accepted push (push=1 and full=0, or push=1 with full=1 and pop=1) SHALL write data_in at wr_ptr and advance wr_ptr by 1.
REQ-018 Accepted pop (pop=1 and empty=0) SHALL load mem[rd_ptr] into data_out, set valid_out=1 on the next cycle, and advance rd_ptr by 1.
REQ-019 Read latency SHALL be exactly 1 clk_f cycle from the pop edge; there is no fall-through, and a byte pushed in cycle N is poppable no earlier than cycle N+1.
REQ-020 valid_out SHALL be 0 in every cycle not following an accepted pop; data_out SHALL hold its last value when valid_out=0.
REQ-021 count SHALL do +1 on push-only, -1 on pop-only, and stay unchanged on simultaneous accepted push and pop.
REQ-022 full SHALL equal (count==DEPTH); empty SHALL equal (count==0); almost flags SHALL decode combinationally from count per REQ-003/004.
REQ-023 Push with full=1 and pop=0 SHALL drop data_in, leave memory and pointers unchanged, and set overflow_err.
REQ-024 Pop with empty=1 SHALL be ignored even if push=1 in the same cycle (push still accepted), and SHALL set underflow_err.
REQ-025 Push and pop with full=1 SHALL both be accepted, and overflow_err SHALL NOT be set.
REQ-026 overflow_err and underflow_err SHALL remain set until reset.

Reset
REQ-027 reset=0 SHALL immediately, without waiting for clk_f, clear the pointers, count, data_out, valid_out, overflow_err and underflow_err.
REQ-028 During reset: empty=1, almost_empty=1, full=0, almost_full=0.
REQ-029 Memory contents need not be cleared.
REQ-030 Reset asserted mid-transfer SHALL discard all stored entries; push/pop in the same cycle as reset are ignored.
REQ-031 After reset deassertion, the first rising clk_f SHALL accept operations normally.

Verification
REQ-032 Push 0xA1..0xA8 on 8 consecutive cycles, then pop 8 -> data_out 0xA1..0xA8 in order, one cycle after each pop; full=1 after the 8th push; empty=1 after the 8th pop.
REQ-033 Fill to 8, push 0xFF -> overflow_err=1, count=8; later pops return 0xA1..0xA8, and 0xFF never appears.
REQ-034 With count=8, push 0x55 and pop in the same cycle -> count=8, overflow_err=0, data_out=head; 0x55 is read last.
REQ-035 Empty FIFO, push 0x3C and pop in the same cycle -> underflow_err=1, valid_out=0 next cycle, count=1; next pop returns 0x3C.
REQ-036 Push 0x10..0x15 (count=6), assert reset low between clock edges -> count=0, empty=1, errors=0, valid_out=0 immediately; a pop after release gives underflow_err=1.
REQ-037 Run 20 pushes interleaved with pops over pointer wrap-around -> output order matches input; almost_full toggles at count 6 and almost_empty at count 2.

Source files
------------

// File: rtl/rx_lane_fifo.sv
// Per-lane receive FIFO behind the 2x4 demux. It has a registered read port, no fall-through,
// and sticky overflow/underflow flags.
module rx_lane_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk_f,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       push,
    input  logic                       pop,
    output logic [WIDTH-1:0]           data_out,
    output logic                       valid_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow_err,
    output logic                       underflow_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_out_q;
    logic             overflow_q, underflow_q;
    logic             push_ok, pop_ok;

    // Push is accepted when there is room, or when the FIFO is full and a pop frees the slot
    // in the same cycle. Pop is accepted whenever the FIFO holds data.
    assign pop_ok  = pop && (count_q != '0);
    assign push_ok = push && ((count_q != DEPTH_C) || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            data_out_d = mem_q[rd_ptr_q];
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage is not reset; the cleared pointers and count make stale entries unreachable.
    always_ff @(posedge clk_f) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            valid_out_q <= pop_ok;
            if (push && (count_q == DEPTH_C) && !pop) begin
                overflow_q <= 1'b1;
            end
            if (pop && (count_q == '0)) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign data_out      = data_out_q;
    assign valid_out     = valid_out_q;
    assign count         = count_q;
    assign full          = (count_q == DEPTH_C);
    assign empty         = (count_q == '0);
    assign almost_full   = (count_q >= AF_C);
    assign almost_empty  = (count_q <= AE_C);
    assign overflow_err  = overflow_q;
    assign underflow_err = underflow_q;

endmodule

// File: tb/tb_rx_lane_fifo.sv
// Self-checking bench for rx_lane_fifo. It runs directed scenarios and randomized traffic
// against a queue-based reference model.
module tb_rx_lane_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic             clk_f = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             valid_out, full, empty, almost_full, almost_empty;
    logic [3:0]       count;
    logic             overflow_err, underflow_err;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] m_data;
    logic             m_valid, m_ovf, m_udf;

    rx_lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .clk_f(clk_f), .reset(reset), .data_in(data_in), .push(push), .pop(pop),
        .data_out(data_out), .valid_out(valid_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk_f = ~clk_f;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = exp_q.size();
        check("count", 32'(count), 32'(n));
        check("full", 32'(full), 32'(n == DEPTH));
        check("empty", 32'(empty), 32'(n == 0));
        check("almost_full", 32'(almost_full), 32'(n >= AF));
        check("almost_empty", 32'(almost_empty), 32'(n <= AE));
        check("valid_out", 32'(valid_out), 32'(m_valid));
        check("data_out", 32'(data_out), 32'(m_data));
        check("overflow_err", 32'(overflow_err), 32'(m_ovf));
        check("underflow_err", 32'(underflow_err), 32'(m_udf));
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    // One clock of traffic. The model applies the acceptance rules, then the outputs are
    // compared just after the edge.
    task automatic step(input logic p, input logic r, input logic [WIDTH-1:0] d);
        bit was_full, was_empty, pop_ok, push_ok;
        @(negedge clk_f);
        push    = p;
        pop     = r;
        data_in = d;
        was_full  = (exp_q.size() == DEPTH);
        was_empty = (exp_q.size() == 0);
        pop_ok    = r && !was_empty;
        push_ok   = p && (!was_full || r);
        m_valid   = pop_ok;
        if (pop_ok) m_data = exp_q.pop_front();
        if (push_ok) exp_q.push_back(d);
        if (p && was_full && !r) m_ovf = 1'b1;
        if (r && was_empty) m_udf = 1'b1;
        @(posedge clk_f);
        #1;
        check_all();
    endtask

    // Asserts reset between clock edges with traffic requested, so the bench can confirm that
    // the clear is immediate and that push/pop are ignored while reset is held.
    task automatic apply_reset();
        @(negedge clk_f);
        #2;
        reset = 1'b0;
        push  = 1'b1;
        pop   = 1'b1;
        data_in = 8'hEE;
        #1;
        model_clear();
        check_all();
        @(posedge clk_f);
        #1;
        check_all();
        @(negedge clk_f);
        reset = 1'b1;
        push  = 1'b0;
        pop   = 1'b0;
    endtask

    initial begin
        model_clear();
        #12;
        check_all();
        @(negedge clk_f);
        reset = 1'b1;

        // In-order fill and drain
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'hA1 + 8'(i));
        check("full_after_8", 32'(full), 32'd1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00);
        check("empty_after_8", 32'(empty), 32'd1);

        // Simultaneous push and pop while full
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'hA1 + 8'(i));
        step(1'b1, 1'b1, 8'h55);
        check("full_pp_head", 32'(data_out), 32'hA1);
        check("full_pp_ovf", 32'(overflow_err), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00);
        check("last_is_55", 32'(data_out), 32'h55);

        // Overflow drop
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'hA2 + 8'(i));
        step(1'b1, 1'b0, 8'hA1);
        apply_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'hA1 + 8'(i));
        step(1'b1, 1'b0, 8'hFF);
        check("ovf_set", 32'(overflow_err), 32'd1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        check("ovf_sticky", 32'(overflow_err), 32'd1);

        // Push and pop together on an empty FIFO
        apply_reset();
        step(1'b1, 1'b1, 8'h3C);
        check("udf_set", 32'(underflow_err), 32'd1);
        step(1'b0, 1'b1, 8'h00);
        check("pop_3c", 32'(data_out), 32'h3C);

        // Reset in the middle of a transfer, then pop an empty FIFO
        apply_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'h10 + 8'(i));
        apply_reset();
        step(1'b0, 1'b1, 8'h00);
        check("udf_after_reset", 32'(underflow_err), 32'd1);

        // Interleaved traffic across pointer wrap-around
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, (i % 3) == 2, 8'(8'h40 + i));
        end
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);

        // Randomized traffic with phases biased toward filling and draining
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = ((i / 50) % 2 == 0) ? 75 : 25;
            step($urandom_range(99) < bias, $urandom_range(99) >= bias,
                 8'($urandom_range(255)));
            if ($urandom_range(199) == 0) apply_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
